s2p_lanes: RTL and testbench



---
 rtl/s2p_lanes.sv | 98 +++++++++
 tb/tb_s2p_lanes.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/s2p_lanes.sv
// Serial-to-parallel converter: gathers LANES accepted words into one flat output group,
// aligned to a frame sync, with run-time lane ordering and truncated-group detection.
module s2p_lanes #(
  parameter int unsigned WORDLENGTH = 16,
  parameter int unsigned LANES      = 4,
  parameter int unsigned LOG2_LANES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          sync,
  input  logic                          order,
  input  logic [WORDLENGTH-1:0]         data_in,
  output logic [LANES*WORDLENGTH-1:0]   data_out,
  output logic                          out_valid,
  output logic [LOG2_LANES-1:0]         slot,
  output logic                          locked,
  output logic                          sync_err
);

  typedef enum logic {StUnlocked, StLocked} state_e;

  localparam logic [LOG2_LANES-1:0] LastSlot  = LOG2_LANES'(LANES - 1);
  localparam logic [LOG2_LANES-1:0] FirstNext = LOG2_LANES'(1);

  state_e                  state_q;
  logic [LOG2_LANES-1:0]   slot_q;
  logic [WORDLENGTH-1:0]   shreg_q [LANES];
  logic [WORDLENGTH-1:0]   shreg_d [LANES];
  logic [LANES*WORDLENGTH-1:0] group;
  logic                    group_done;

  // Register contents as they will be after this edge's shift; word 0 is the newest sample.
  always_comb begin
    shreg_d[0] = data_in;
    for (int unsigned i = 1; i < LANES; i++) begin
      shreg_d[i] = shreg_q[i-1];
    end
  end

  // Legacy order puts the newest sample in lane 0; natural order puts the oldest there.
  always_comb begin
    group = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      group[k*WORDLENGTH +: WORDLENGTH] = order ? shreg_d[LANES-1-k] : shreg_d[k];
    end
  end

  assign group_done = enable && !sync && (state_q == StLocked) && (slot_q == LastSlot);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StUnlocked;
      slot_q    <= '0;
      data_out  <= '0;
      out_valid <= 1'b0;
      sync_err  <= 1'b0;
      for (int unsigned i = 0; i < LANES; i++) begin
        shreg_q[i] <= '0;
      end
    end else begin
      out_valid <= group_done;
      sync_err  <= 1'b0;
      if (enable) begin
        for (int unsigned i = 0; i < LANES; i++) begin
          shreg_q[i] <= shreg_d[i];
        end
      end
      if (group_done) begin
        data_out <= group;
      end
      unique case (state_q)
        StUnlocked: begin
          if (enable && sync) begin
            state_q <= StLocked;
            slot_q  <= FirstNext;
          end
        end
        StLocked: begin
          if (enable) begin
            if (sync) begin
              // A sync landing mid-group drops the partial group and restarts at slot 0.
              sync_err <= (slot_q != '0);
              slot_q   <= FirstNext;
            end else begin
              slot_q <= slot_q + FirstNext;
            end
          end
        end
        default: state_q <= StUnlocked;
      endcase
    end
  end

  assign slot   = slot_q;
  assign locked = (state_q == StLocked);

endmodule

// File: tb/tb_s2p_lanes.sv
// Bench for s2p_lanes: directed vector table, hand sequences and a randomized run
// checked against a group-queue reference model.
module tb_s2p_lanes;
  localparam int WL = 16;
  localparam int LN = 4;
  localparam int LG = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              enable = 1'b0;
  logic              sync = 1'b0;
  logic              order = 1'b0;
  logic [WL-1:0]     data_in = '0;
  logic [LN*WL-1:0]  data_out;
  logic              out_valid;
  logic [LG-1:0]     slot;
  logic              locked;
  logic              sync_err;

  s2p_lanes #(.WORDLENGTH(WL), .LANES(LN), .LOG2_LANES(LG)) dut (
    .clk(clk), .rst(rst), .enable(enable), .sync(sync), .order(order), .data_in(data_in),
    .data_out(data_out), .out_valid(out_valid), .slot(slot), .locked(locked),
    .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: the words of the group in progress, in arrival order.
  logic          m_locked;
  logic [WL-1:0] m_grp[$];
  logic [63:0]   m_data;
  logic          m_valid;
  logic          m_err;

  typedef struct {
    logic        en;
    logic        sy;
    logic        ord;
    logic [15:0] din;
    logic        ev;
    logic        eerr;
    logic        elk;
    logic [1:0]  eslot;
    logic [63:0] edata;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_locked = 1'b0;
    m_grp.delete();
    m_data  = '0;
    m_valid = 1'b0;
    m_err   = 1'b0;
  endtask

  task automatic model_step(input logic en, input logic sy, input logic ord,
                            input logic [WL-1:0] din);
    m_valid = 1'b0;
    m_err   = 1'b0;
    if (en) begin
      if (sy) begin
        m_err    = m_locked && (m_grp.size() != 0);
        m_locked = 1'b1;
        m_grp.delete();
        m_grp.push_back(din);
      end else if (m_locked) begin
        m_grp.push_back(din);
        if (m_grp.size() == LN) begin
          for (int k = 0; k < LN; k++) begin
            m_data[k*WL +: WL] = ord ? m_grp[k] : m_grp[LN-1-k];
          end
          m_valid = 1'b1;
          m_grp.delete();
        end
      end
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ":out_valid"}, 64'(out_valid), 64'(m_valid));
    chk({tag, ":sync_err"}, 64'(sync_err), 64'(m_err));
    chk({tag, ":locked"}, 64'(locked), 64'(m_locked));
    chk({tag, ":slot"}, 64'(slot), 64'(m_grp.size()));
    chk({tag, ":data_out"}, 64'(data_out), m_data);
  endtask

  task automatic step(input logic en, input logic sy, input logic ord, input logic [WL-1:0] din);
    enable  = en;
    sync    = sy;
    order   = ord;
    data_in = din;
    @(posedge clk);
    model_step(en, sy, ord, din);
    #1;
    check_model("model");
  endtask

  // Called #1 after an edge; checks the asynchronous clear before the next edge.
  task automatic do_reset(input string tag);
    rst = 1'b0;
    #1;
    chk({tag, ":rst_data_out"}, 64'(data_out), 64'h0);
    chk({tag, ":rst_out_valid"}, 64'(out_valid), 64'h0);
    chk({tag, ":rst_slot"}, 64'(slot), 64'h0);
    chk({tag, ":rst_locked"}, 64'(locked), 64'h0);
    chk({tag, ":rst_sync_err"}, 64'(sync_err), 64'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    int vcount;
    int vcyc[$];
    logic [63:0] vdat[$];
    int cyc;

    // en sy ord din | valid err locked slot data
    vecs.push_back('{1, 1, 0, 16'h0001, 0, 0, 1, 2'd1, 64'h0});
    vecs.push_back('{1, 0, 0, 16'h0002, 0, 0, 1, 2'd2, 64'h0});
    vecs.push_back('{1, 0, 1, 16'h0003, 0, 0, 1, 2'd3, 64'h0});
    vecs.push_back('{1, 0, 0, 16'h0004, 1, 0, 1, 2'd0, 64'h0001_0002_0003_0004});
    vecs.push_back('{0, 0, 0, 16'h0055, 0, 0, 1, 2'd0, 64'h0001_0002_0003_0004});
    vecs.push_back('{1, 1, 0, 16'h00A0, 0, 0, 1, 2'd1, 64'h0001_0002_0003_0004});
    vecs.push_back('{1, 0, 0, 16'h00A1, 0, 0, 1, 2'd2, 64'h0001_0002_0003_0004});
    vecs.push_back('{1, 1, 0, 16'h00B0, 0, 1, 1, 2'd1, 64'h0001_0002_0003_0004});
    vecs.push_back('{1, 0, 1, 16'h00B1, 0, 0, 1, 2'd2, 64'h0001_0002_0003_0004});
    vecs.push_back('{1, 0, 0, 16'h00B2, 0, 0, 1, 2'd3, 64'h0001_0002_0003_0004});
    vecs.push_back('{1, 0, 1, 16'h00B3, 1, 0, 1, 2'd0, 64'h00B3_00B2_00B1_00B0});
    vecs.push_back('{0, 1, 0, 16'h00C0, 0, 0, 1, 2'd0, 64'h00B3_00B2_00B1_00B0});

    // Reset and idle
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset:data_out", 64'(data_out), 64'h0);
    chk("reset:locked", 64'(locked), 64'h0);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'(i % 2), 1'b0, WL'($urandom));
      chk("idle:out_valid", 64'(out_valid), 64'h0);
      chk("idle:slot", 64'(slot), 64'h0);
    end

    // Directed table: legacy order, hold, truncating sync, order sampled on completion
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].en, vecs[i].sy, vecs[i].ord, vecs[i].din);
      chk($sformatf("vec%0d:out_valid", i), 64'(out_valid), 64'(vecs[i].ev));
      chk($sformatf("vec%0d:sync_err", i), 64'(sync_err), 64'(vecs[i].eerr));
      chk($sformatf("vec%0d:locked", i), 64'(locked), 64'(vecs[i].elk));
      chk($sformatf("vec%0d:slot", i), 64'(slot), 64'(vecs[i].eslot));
      chk($sformatf("vec%0d:data_out", i), 64'(data_out), vecs[i].edata);
    end

    // Natural order, back-to-back groups
    cyc = 0;
    for (int d = 16'h10; d <= 16'h17; d++) begin
      step(1'b1, d == 16'h10, 1'b1, WL'(d));
      cyc++;
      if (out_valid) begin
        vcyc.push_back(cyc);
        vdat.push_back(64'(data_out));
      end
    end
    chk("b2b:pulses", 64'(vcyc.size()), 64'd2);
    if (vcyc.size() == 2) begin
      chk("b2b:spacing", 64'(vcyc[1] - vcyc[0]), 64'd4);
      chk("b2b:group0", vdat[0], 64'h0013_0012_0011_0010);
      chk("b2b:group1", vdat[1], 64'h0017_0016_0015_0014);
    end

    // Enable gaps; sync during a gap must be ignored
    vcount = 0;
    step(1'b1, 1'b1, 1'b0, 16'h0001);
    for (int s = 2; s <= 4; s++) begin
      repeat (3) begin
        step(1'b0, 1'b1, 1'b0, WL'($urandom));
        chk("gap:slot_hold", 64'(slot), 64'(s - 1));
        if (out_valid) vcount++;
      end
      step(1'b1, 1'b0, 1'b0, WL'(s));
      if (out_valid) vcount++;
    end
    chk("gap:valid_last", 64'(out_valid), 64'h1);
    chk("gap:data", 64'(data_out), 64'h0001_0002_0003_0004);
    chk("gap:pulses", 64'(vcount), 64'd1);

    // Pre-lock samples, then mid-group reset
    do_reset("prelock");
    vcount = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, 1'(i % 2), WL'(16'h40 + i));
      if (out_valid) vcount++;
      chk("prelock:locked", 64'(locked), 64'h0);
    end
    chk("prelock:pulses", 64'(vcount), 64'd0);
    step(1'b1, 1'b1, 1'b0, 16'h0021);
    for (int d = 16'h22; d <= 16'h24; d++) step(1'b1, 1'b0, 1'b0, WL'(d));
    step(1'b1, 1'b0, 1'b0, 16'h0031);
    step(1'b1, 1'b0, 1'b0, 16'h0032);
    do_reset("midgrp");
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b0, WL'(16'h50 + i));
      chk("postrst:locked", 64'(locked), 64'h0);
      chk("postrst:out_valid", 64'(out_valid), 64'h0);
    end
    step(1'b1, 1'b1, 1'b0, 16'h0060);
    chk("relock:locked", 64'(locked), 64'h1);

    // Randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset("rand");
      end else begin
        step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0),
             1'($urandom), WL'($urandom));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
